// File: rtl/cpu_mem_bridge_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : cpu_mem_bridge_pkg                                                |
// | Brief  : Shared I/O map, stop-FSM encodings and read-selector types.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_mem_bridge_pkg;

  localparam logic [17:0] IO_RX_ADDR  = 18'h3_0000;
  localparam logic [17:0] IO_CNT_ADDR = 18'h3_0004;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_RX   = 2'd1,
    SRC_CNT  = 2'd2,
    SRC_ZERO = 2'd3
  } rd_src_e;

  // Everything needed in the second read cycle to form cpu_din.
  typedef struct packed {
    logic       valid;
    rd_src_e    src;
    logic [1:0] byte_idx;
    logic [7:0] rx_byte;
  } rd_sel_t;

  function automatic logic [7:0] cnt_byte(input logic [31:0] v, input logic [1:0] k);
    return v[{k, 3'b000} +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_mem_bridge_if.sv
// +----------------------------------------------------------------------------+
// | Module : cpu_mem_bridge_if                                                 |
// | Brief  : CPU byte bus, RAM port, RX/TX byte streams and stop flag.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cpu_mem_bridge_if #(
  parameter int RAM_AW = 17
);
  logic [31:0]       cpu_a;
  logic [7:0]        cpu_dout;
  logic              cpu_wr;
  logic [7:0]        cpu_din;
  logic              cpu_rdy;
  logic [RAM_AW-1:0] ram_a;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic [7:0]        ram_rdata;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_pop;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              prog_end;

  modport master (
    output cpu_a, cpu_dout, cpu_wr, ram_rdata, rx_valid, rx_data, tx_ready,
    input  cpu_din, cpu_rdy, ram_a, ram_wdata, ram_we, rx_pop, tx_valid, tx_data, prog_end
  );

  modport slave (
    input  cpu_a, cpu_dout, cpu_wr, ram_rdata, rx_valid, rx_data, tx_ready,
    output cpu_din, cpu_rdy, ram_a, ram_wdata, ram_we, rx_pop, tx_valid, tx_data, prog_end
  );
endinterface

`default_nettype wire

// File: rtl/cpu_mem_bridge_byte_fifo.sv
// +----------------------------------------------------------------------------+
// | Module : byte_fifo                                                         |
// | Brief  : Single-clock byte FIFO with occupancy count; full push dropped.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  wire logic                     clk_in,
  input  wire logic                     rst_in,
  input  wire logic                     push,
  input  wire logic [7:0]               din,
  output logic                          full,
  input  wire logic                     pop,
  output logic [7:0]                    dout,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign count     = r_cnt;
  assign dout      = r_mem[r_rp];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wp] <= din;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_mem_bridge.sv
// +----------------------------------------------------------------------------+
// | Module : cpu_mem_bridge                                                    |
// | Brief  : CPU memory-bus decode, 2-cycle reads, cycle counter, TX FIFO and  |
// |          program-stop sequencing.                                          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpu_mem_bridge
  import cpu_mem_bridge_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RAM_AW   = 17
) (
  input  wire logic       clk_in,
  input  wire logic       rst_in,
  cpu_mem_bridge_if.slave bus
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic          r_up;
  logic [1:0]    r_state;
  logic [31:0]   r_cnt;
  logic [31:0]   r_snap;
  rd_sel_t       r_sel;
  logic [7:0]    r_din;

  logic          w_rdy;
  logic          w_rd;
  logic          w_hit_rx;
  logic          w_hit_cnt0;
  logic          w_hit_cnt;
  logic          w_stop;
  logic          w_tx_wr;
  logic          w_push;
  logic [7:0]    w_push_data;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_fifo_dout;
  logic [CW-1:0] w_count;
  rd_src_e       w_src;
  logic          w_unused;

  assign w_unused   = &{1'b0, bus.cpu_a[31:18], w_full};

  assign w_hit_rx   = (bus.cpu_a[17:0] == IO_RX_ADDR);
  assign w_hit_cnt0 = (bus.cpu_a[17:0] == IO_CNT_ADDR);
  assign w_hit_cnt  = (bus.cpu_a[17:2] == IO_CNT_ADDR[17:2]);

  // The top FIFO slot is held back so the stop marker always fits.
  assign w_rdy      = r_up && (r_state == ST_RUN) && (w_count < CW'(TX_DEPTH - 1));
  assign w_rd       = ~bus.cpu_wr & w_rdy;

  assign w_stop      = bus.cpu_wr && w_hit_cnt0 && r_up && (r_state == ST_RUN);
  assign w_tx_wr     = bus.cpu_wr && w_hit_rx && w_rdy && (bus.cpu_dout != 8'h00);
  assign w_push      = w_stop | w_tx_wr;
  assign w_push_data = w_stop ? 8'h00 : bus.cpu_dout;
  assign w_pop       = ~w_empty & bus.tx_ready;

  always_comb begin
    w_src = SRC_RAM;
    if (bus.cpu_a[17]) begin
      if (w_hit_rx)       w_src = SRC_RX;
      else if (w_hit_cnt) w_src = SRC_CNT;
      else                w_src = SRC_ZERO;
    end
  end

  assign bus.ram_a     = bus.cpu_a[RAM_AW-1:0];
  assign bus.ram_wdata = bus.cpu_dout;
  assign bus.ram_we    = bus.cpu_wr & ~bus.cpu_a[17] & w_rdy;
  assign bus.rx_pop    = w_rd & w_hit_rx & bus.rx_valid;
  assign bus.cpu_din   = r_din;
  assign bus.cpu_rdy   = w_rdy;
  assign bus.tx_valid  = ~w_empty;
  assign bus.tx_data   = w_fifo_dout;
  assign bus.prog_end  = (r_state == ST_HALT);

  byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (w_push),
    .din    (w_push_data),
    .full   (w_full),
    .pop    (w_pop),
    .dout   (w_fifo_dout),
    .empty  (w_empty),
    .count  (w_count)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_up    <= 1'b0;
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_snap  <= '0;
      r_sel   <= '0;
      r_din   <= '0;
    end else begin
      r_up  <= 1'b1;
      r_cnt <= r_cnt + 32'd1;

      // The RX byte is captured in the address cycle because it is popped there.
      r_sel.valid    <= w_rd;
      r_sel.src      <= w_src;
      r_sel.byte_idx <= bus.cpu_a[1:0];
      r_sel.rx_byte  <= bus.rx_valid ? bus.rx_data : 8'h00;

      if (w_rd && w_hit_cnt0) r_snap <= r_cnt;

      if (r_sel.valid) begin
        case (r_sel.src)
          SRC_RAM: r_din <= bus.ram_rdata;
          SRC_RX:  r_din <= r_sel.rx_byte;
          SRC_CNT: r_din <= cnt_byte(r_snap, r_sel.byte_idx);
          default: r_din <= 8'h00;
        endcase
      end

      case (r_state)
        ST_RUN:   if (w_stop)  r_state <= ST_DRAIN;
        ST_DRAIN: if (w_empty) r_state <= ST_HALT;
        ST_HALT:  r_state <= ST_HALT;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_bridge.sv
// +----------------------------------------------------------------------------+
// | Module : tb_cpu_mem_bridge                                                 |
// | Brief  : Directed self-checking bench for cpu_mem_bridge.                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cpu_mem_bridge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] ram [0:131071];
  logic [7:0] txq [$];
  logic [7:0] d;

  cpu_mem_bridge_if #(.RAM_AW(17)) bus ();

  cpu_mem_bridge #(
    .TX_DEPTH (16),
    .RAM_AW   (17)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_a] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_a];
  end

  always @(posedge clk) begin
    if (rst_n && bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.cpu_a    = 32'h0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_dout = 8'h00;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] data);
    bus.cpu_a    = addr;
    bus.cpu_wr   = 1'b1;
    bus.cpu_dout = data;
    @(negedge clk);
    idle();
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [7:0] q);
    bus.cpu_a  = addr;
    bus.cpu_wr = 1'b0;
    @(negedge clk);
    idle();
    @(negedge clk);
    q = bus.cpu_din;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    idle();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_rdy",      bus.cpu_rdy,  0);
    check_eq("rst_din",      bus.cpu_din,  0);
    check_eq("rst_tx_valid", bus.tx_valid, 0);
    check_eq("rst_prog_end", bus.prog_end, 0);
    check_eq("rst_rx_pop",   bus.rx_pop,   0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rdy_after_rst", bus.cpu_rdy, 1);

    // 1: RAM write then 2-cycle read
    bus.cpu_a = 32'h10; bus.cpu_wr = 1'b1; bus.cpu_dout = 8'hA5;
    #1 check_eq("ram_we_wr", bus.ram_we, 1);
    @(negedge clk);
    bus.cpu_a = 32'h10; bus.cpu_wr = 1'b0; bus.cpu_dout = 8'h00;
    #1 check_eq("ram_we_rdN", bus.ram_we, 0);
    @(negedge clk);
    idle();
    #1 check_eq("ram_we_rdN1", bus.ram_we, 0);
    @(negedge clk);
    check_eq("ram_rd", bus.cpu_din, 8'hA5);

    // 2: RX read with and without a byte available
    bus.rx_valid = 1'b1; bus.rx_data = 8'h41;
    bus.cpu_a = 32'h3_0000; bus.cpu_wr = 1'b0;
    #1 check_eq("rx_pop_N", bus.rx_pop, 1);
    @(negedge clk);
    idle();
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    #1 check_eq("rx_pop_N1", bus.rx_pop, 0);
    @(negedge clk);
    check_eq("rx_data", bus.cpu_din, 8'h41);
    bus.cpu_a = 32'h3_0000;
    #1 check_eq("rx_nopop", bus.rx_pop, 0);
    @(negedge clk);
    idle();
    @(negedge clk);
    check_eq("rx_empty", bus.cpu_din, 8'h00);
    do_read(32'h3_0010, d);
    check_eq("io_other_rd", d, 8'h00);

    // 3: zero byte is not transmitted
    bus.tx_ready = 1'b1;
    do_write(32'h3_0000, 8'h48);
    do_write(32'h3_0000, 8'h00);
    do_write(32'h3_0000, 8'h69);
    repeat (4) @(negedge clk);
    check_eq("tx3_size", txq.size(), 2);
    check_eq("tx3_b0", txq[0], 8'h48);
    check_eq("tx3_b1", txq[1], 8'h69);
    txq.delete();

    // 4: back-pressure at TX_DEPTH-1 entries
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      do_write(32'h3_0000, 8'(8'h80 + i));
      if (i == 13) check_eq("rdy_cnt14", bus.cpu_rdy, 1);
    end
    check_eq("rdy_cnt15", bus.cpu_rdy, 0);
    check_eq("tx4_valid", bus.tx_valid, 1);
    bus.tx_ready = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("tx4_size", txq.size(), 15);
    for (int i = 0; i < 15; i++) check_eq("tx4_order", txq[i], 32'(8'h80 + i));
    check_eq("rdy_drained", bus.cpu_rdy, 1);
    txq.delete();

    // 5: coherent counter snapshot and wrap
    force dut.r_cnt = 32'hFFFF_FFFE;
    bus.cpu_a = 32'h3_0004; bus.cpu_wr = 1'b0;
    @(posedge clk);
    #1 release dut.r_cnt;
    @(negedge clk);
    idle();
    @(negedge clk);
    check_eq("cnt_b0", bus.cpu_din, 8'hFE);
    do_read(32'h3_0005, d); check_eq("cnt_b1", d, 8'hFF);
    do_read(32'h3_0006, d); check_eq("cnt_b2", d, 8'hFF);
    do_read(32'h3_0007, d); check_eq("cnt_b3", d, 8'hFF);
    repeat (2) @(negedge clk);
    do_read(32'h3_0004, d);
    do_read(32'h3_0005, d); check_eq("wrap_b1", d, 8'h00);
    do_read(32'h3_0007, d); check_eq("wrap_b3", d, 8'h00);

    // 6: program stop drains the queue then halts
    bus.tx_ready = 1'b0;
    do_write(32'h3_0000, 8'h11);
    do_write(32'h3_0000, 8'h22);
    do_write(32'h3_0000, 8'h33);
    do_write(32'h3_0004, 8'h5A);
    check_eq("stop_rdy", bus.cpu_rdy, 0);
    check_eq("stop_prog_end", bus.prog_end, 0);
    repeat (2) @(negedge clk);
    check_eq("drain_hold", bus.prog_end, 0);
    bus.tx_ready = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("tx6_size", txq.size(), 4);
    check_eq("tx6_b0", txq[0], 8'h11);
    check_eq("tx6_b1", txq[1], 8'h22);
    check_eq("tx6_b2", txq[2], 8'h33);
    check_eq("tx6_b3", txq[3], 8'h00);
    check_eq("halt_prog_end", bus.prog_end, 1);
    check_eq("halt_rdy", bus.cpu_rdy, 0);
    bus.cpu_a = 32'h20; bus.cpu_wr = 1'b1; bus.cpu_dout = 8'h77;
    #1 check_eq("halt_ram_we", bus.ram_we, 0);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst2_prog_end", bus.prog_end, 0);
    check_eq("rst2_rdy", bus.cpu_rdy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst2_rdy_up", bus.cpu_rdy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
